// File: rtl/player_input_ctrl.sv
// player_input_ctrl: debounced N-player select/lock front end with start/game-over handshake
module player_input_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_CHOICES     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int CW             = $clog2(NUM_CHOICES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PLAYERS-1:0]    sel,
  input  logic [NUM_PLAYERS-1:0]    conf,
  input  logic                      start,
  input  logic                      game_over,
  output logic [NUM_PLAYERS*CW-1:0] choice,
  output logic [NUM_PLAYERS-1:0]    locked,
  output logic                      all_locked,
  output logic                      game_start,
  output logic [1:0]                phase
);
  localparam int NCH = 2*NUM_PLAYERS+1;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES+1);
  localparam logic [1:0] SELECT  = 2'd0;
  localparam logic [1:0] READY   = 2'd1;
  localparam logic [1:0] RUNNING = 2'd2;
  logic [NCH-1:0] raw, s1_q, s2_q, lvl_q, lvl_d, press_q, press_d;
  logic [DW-1:0] cnt_q [NCH];
  logic [DW-1:0] cnt_d [NCH];
  logic [NUM_PLAYERS*CW-1:0] choice_q, choice_d;
  logic [NUM_PLAYERS-1:0] locked_q, locked_d, sp, cp;
  logic [1:0] phase_q, phase_d;
  logic game_start_q, game_start_d, stp;
  assign raw = {start, conf, sel};
  // Counter runs only while the synchronised sample disagrees with the accepted level.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = (s2_q[i] == lvl_q[i]) ? '0 : cnt_q[i] + DW'(1);
      lvl_d[i] = (s2_q[i] != lvl_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES-1)) ? ~lvl_q[i] : lvl_q[i];
      cnt_d[i] = (lvl_d[i] != lvl_q[i]) ? '0 : cnt_d[i];
      press_d[i] = lvl_d[i] & ~lvl_q[i];
    end
  end
  assign sp  = press_q[NUM_PLAYERS-1:0];
  assign cp  = press_q[2*NUM_PLAYERS-1:NUM_PLAYERS];
  assign stp = press_q[2*NUM_PLAYERS];
  always_comb begin
    choice_d     = choice_q;
    locked_d     = locked_q;
    phase_d      = phase_q;
    game_start_d = 1'b0;
    case (phase_q)
      SELECT: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (sp[p] && !locked_q[p])
            choice_d[p*CW +: CW] = (choice_q[p*CW +: CW] == CW'(NUM_CHOICES-1)) ? '0
                                   : choice_q[p*CW +: CW] + CW'(1);
          if (cp[p]) locked_d[p] = 1'b1;
        end
        phase_d = (&locked_q) ? READY : SELECT;
      end
      READY: begin
        if (|cp) begin
          locked_d = locked_q & ~cp;
          phase_d  = SELECT;
        end else if (stp) begin
          game_start_d = 1'b1;
          phase_d      = RUNNING;
        end
      end
      RUNNING: begin
        locked_d = game_over ? '0 : locked_q;
        phase_d  = game_over ? SELECT : RUNNING;
      end
      default: phase_d = SELECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      lvl_q        <= '0;
      press_q      <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      choice_q     <= '0;
      locked_q     <= '0;
      phase_q      <= SELECT;
      game_start_q <= 1'b0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      lvl_q        <= lvl_d;
      press_q      <= press_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      choice_q     <= choice_d;
      locked_q     <= locked_d;
      phase_q      <= phase_d;
      game_start_q <= game_start_d;
    end
  end
  assign choice     = choice_q;
  assign locked     = locked_q;
  assign all_locked = &locked_q;
  assign game_start = game_start_q;
  assign phase      = phase_q;
endmodule
